// File: rtl/fsm_stream_sched.sv
// Serialises one requester's job word into a shared FSM and collects its y bits.
// Define FSM_STREAM_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fsm_stream_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    fsm_clr,
    output logic                    fsm_x,
    output logic                    fsm_valid,
    input  logic                    fsm_y,
    output logic                    busy,
    output logic                    done,
    output logic [IW-1:0]           done_id,
    output logic [WIDTH-1:0]        result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   collect;
    logic [WIDTH-1:0]   collect_next;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      winner_q;
    logic               valid_q;

    logic [IW-1:0]      base;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      winner;
    logic               found;

`ifdef FSM_STREAM_SCHED_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0]      ptr;
    assign base = ptr;
`endif

    // Scan from the highest offset down so the closest requester to base wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = base + IW'(i);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // y for bit k arrives one cycle after bit k, so it shifts in from the top, LSB-first.
    assign collect_next = {fsm_y, collect[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            fsm_clr   <= 1'b0;
            fsm_x     <= 1'b0;
            fsm_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            result    <= '0;
            shreg     <= '0;
            collect   <= '0;
            cnt       <= '0;
            winner_q  <= '0;
            valid_q   <= 1'b0;
`ifndef FSM_STREAM_SCHED_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            gnt     <= '0;
            fsm_clr <= 1'b0;
            done    <= 1'b0;
            valid_q <= fsm_valid;
            if (valid_q) begin
                collect <= collect_next;
            end
            case (state)
                IDLE: begin
                    fsm_valid <= 1'b0;
                    fsm_x     <= 1'b0;
                    busy      <= 1'b0;
                    if (found) begin
                        gnt[winner] <= 1'b1;
                        fsm_clr     <= 1'b1;
                        busy        <= 1'b1;
                        shreg       <= req_data[int'(winner)*WIDTH +: WIDTH];
                        cnt         <= '0;
                        winner_q    <= winner;
`ifndef FSM_STREAM_SCHED_FIXED_PRIO_EN
                        ptr         <= winner + IW'(1);
`endif
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    fsm_valid <= 1'b1;
                    fsm_x     <= shreg[0];
                    shreg     <= shreg >> 1;
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    fsm_valid <= 1'b0;
                    fsm_x     <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    done    <= 1'b1;
                    done_id <= winner_q;
                    result  <= collect_next;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_x_quiet:    assert property (@(posedge clk) disable iff (!rst_n) !fsm_valid |-> !fsm_x);
    a_done_busy:  assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
`endif

endmodule

// File: tb/tb_fsm_stream_sched.sv
// Directed self-checking bench for fsm_stream_sched with a 3-bit ones-counting reference FSM.
module tb_fsm_stream_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]    gnt;
    logic               fsm_clr;
    logic               fsm_x;
    logic               fsm_valid;
    logic               fsm_y = 1'b0;
    logic               busy;
    logic               done;
    logic [1:0]         done_id;
    logic [WIDTH-1:0]   result;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    fsm_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .fsm_clr(fsm_clr), .fsm_x(fsm_x), .fsm_valid(fsm_valid),
        .fsm_y(fsm_y), .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference shared FSM: counts ones mod 8, y = (new count < 3), cleared by fsm_clr.
    logic [2:0] m_state = 3'd0;
    always @(posedge clk) begin
        if (fsm_clr) begin
            m_state <= 3'd0;
        end else if (fsm_valid) begin
            m_state <= m_state + {2'b00, fsm_x};
            fsm_y   <= ((m_state + {2'b00, fsm_x}) < 3'd3);
        end
    end

    task automatic wait_gnt(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [WIDTH+NREQ+7:0] all_out;
        #1 rst_n = 1'b0;
        @(negedge clk);
        all_out = {gnt, fsm_clr, fsm_x, fsm_valid, busy, done, done_id, result};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            all_out = {gnt, fsm_clr, fsm_x, fsm_valid, busy, done, done_id, result};
            n_checks++;
            if (all_out !== '0) begin
                n_fail++;
                $display("[TB] FAIL idle_no_req[%0d]: got %h, expected 0", i, all_out);
            end
        end
    endtask

    task automatic test_single_job();
        logic [7:0] d;
        d = 8'hA5;
        req_data[7:0] = d;
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({gnt, fsm_clr, busy, fsm_valid} !== {4'b0001, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got gnt=%b clr=%b busy=%b valid=%b, expected 0001 1 1 0",
                     gnt, fsm_clr, busy, fsm_valid);
        end
        req = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({fsm_valid, fsm_x} !== {1'b1, d[k]}) begin
                n_fail++;
                $display("[TB] FAIL single_bit%0d: got valid=%b x=%b, expected 1 %b", k, fsm_valid, fsm_x, d[k]);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({fsm_valid, fsm_x, done, busy} !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL single_drain: got valid/x/done/busy=%b, expected 0001", {fsm_valid, fsm_x, done, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, done_id, result} !== {1'b1, 1'b1, 2'd0, 8'h1F}) begin
            n_fail++;
            $display("[TB] FAIL single_done: got done=%b busy=%b id=%0d result=%h, expected 1 1 0 1f",
                     done, busy, done_id, result);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, result} !== {1'b0, 1'b0, 8'h1F}) begin
            n_fail++;
            $display("[TB] FAIL single_after: got done=%b busy=%b result=%h, expected 0 0 1f", done, busy, result);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5];
        int prev_cycle;
        logic ok;
`ifdef FSM_STREAM_SCHED_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_data = 32'h4433_2211;
        req = 4'b1111;
        prev_cycle = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(20, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL rr_grant%0d: got no grant within 20 cycles, expected gnt[%0d]", g, exp_seq[g]);
            end else begin
                if (gnt !== 4'(1 << exp_seq[g])) begin
                    n_fail++;
                    $display("[TB] FAIL rr_grant%0d: got gnt=%b, expected requester %0d", g, gnt, exp_seq[g]);
                end
                if (g > 0) begin
                    n_checks++;
                    if (cycle - prev_cycle != WIDTH + 3) begin
                        n_fail++;
                        $display("[TB] FAIL rr_spacing%0d: got %0d cycles, expected %0d", g, cycle - prev_cycle, WIDTH + 3);
                    end
                end
                prev_cycle = cycle;
            end
        end
        req = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        logic ok;
        logic [WIDTH+NREQ+7:0] all_out;
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        wait_gnt(3, ok);
        n_checks++;
        if (!ok || gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL midrst_grant: got gnt=%b, expected 0001", gnt);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        all_out = {gnt, fsm_clr, fsm_x, fsm_valid, busy, done, done_id, result};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_async: got %h, expected 0", all_out);
        end
        repeat (2) @(negedge clk);
        all_out = {gnt, fsm_clr, fsm_x, fsm_valid, busy, done, done_id, result};
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_hold: got %h, expected 0", all_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({gnt, done} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_regrant: got gnt=%b done=%b, expected 0001 0", gnt, done);
        end
        req = 4'b0000;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({done, done_id, result} !== {1'b1, 2'd0, 8'h1F}) begin
            n_fail++;
            $display("[TB] FAIL midrst_rerun: got done=%b id=%0d result=%h, expected 1 0 1f", done, done_id, result);
        end
    endtask

    task automatic test_late_request();
        logic ok;
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_gnt(3, ok);
        n_checks++;
        if (!ok || gnt !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL late_grant1: got gnt=%b, expected 0010", gnt);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        req = 4'b0100;
        req_data[23:16] = 8'hF0;
        req_data[15:8]  = 8'hFF;
        repeat (7) @(negedge clk);
        n_checks++;
        if ({done, done_id, result, gnt} !== {1'b1, 2'd1, 8'h0F, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL late_done1: got done=%b id=%0d result=%h gnt=%b, expected 1 1 0f 0000",
                     done, done_id, result, gnt);
        end
        @(negedge clk);
        n_checks++;
        if ({gnt, busy} !== {4'b0100, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL late_grant2: got gnt=%b busy=%b, expected 0100 1", gnt, busy);
        end
        req = 4'b0000;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({done, done_id, result} !== {1'b1, 2'd2, 8'h3F}) begin
            n_fail++;
            $display("[TB] FAIL late_done2: got done=%b id=%0d result=%h, expected 1 2 3f", done, done_id, result);
        end
    endtask

    task automatic test_all_zero();
        logic ok;
        req_data[7:0] = 8'h00;
        req = 4'b0001;
        wait_gnt(3, ok);
        n_checks++;
        if (!ok || gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL zero_grant: got gnt=%b, expected 0001", gnt);
        end
        req = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({fsm_valid, fsm_x} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL zero_bit%0d: got valid=%b x=%b, expected 1 0", k, fsm_valid, fsm_x);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({fsm_valid, done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL zero_drain: got valid=%b done=%b, expected 0 0", fsm_valid, done);
        end
        @(negedge clk);
        n_checks++;
        if ({done, done_id, result} !== {1'b1, 2'd0, 8'hFF}) begin
            n_fail++;
            $display("[TB] FAIL zero_done: got done=%b id=%0d result=%h, expected 1 0 ff", done, done_id, result);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, busy, result} !== {1'b0, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("[TB] FAIL zero_hold: got done=%b busy=%b result=%h, expected 0 0 ff", done, busy, result);
        end
    endtask

    initial begin
        $display("[TB] starting fsm_stream_sched directed tests");
        test_reset();
        test_single_job();
        test_round_robin();
        test_reset_mid_job();
        test_late_request();
        test_all_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected completion", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
